// File: rtl/neuron_config_loader_if.sv
// ----------------------------------------------------------------------------
// neuron_config_loader_if
//   Host-to-loader word stream.
//   Handshake: a word moves on a rising clock edge exactly when in_valid and
//   in_ready are both 1. While in_valid is 1 the master holds in_data stable.
//   in_ready may change at any time and does not depend on in_valid.
//   Signals:
//     in_data   [W-1:0]  stream word (header, weight or bias)
//     in_valid           master has a word on in_data
//     in_ready           slave will take the word at the next edge
//   Modports:
//     master  host side (drives data/valid)
//     slave   loader side (drives ready)
// ----------------------------------------------------------------------------
interface neuron_config_loader_if #(
    parameter int W = 32
);
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/neuron_config_loader.sv
// ----------------------------------------------------------------------------
// neuron_config_loader
//   Writer side of the neuron weight/bias load port. Parses a host word stream
//   of packets (header, N weights, one bias) and broadcasts each weight/bias
//   as a registered one-cycle strobe, tagged with the target layer/neuron.
//   Ports:
//     clk, rst_n         clock (rising edge), asynchronous active-low reset
//     s_if               host stream (slave modport: in_data/in_valid/in_ready)
//     weightValue/Valid  weight word and its one-cycle strobe
//     biasValue/Valid    bias word and its one-cycle strobe
//     config_layer_num   target layer, zero-extended header field
//     config_neuron_num  target neuron, zero-extended header field
//     cfg_done           one-cycle pulse once a neuron's bias has been issued
//     cfg_err            sticky flag for an illegal weight count
//     dbg_state_o        current FSM state, for observation only
// ----------------------------------------------------------------------------
module neuron_config_loader #(
    parameter int dataWidth = 16,
    parameter int maxWeight = 784,
    parameter int cntWidth  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    neuron_config_loader_if.slave    s_if,
    output logic [2*dataWidth-1:0]   weightValue,
    output logic                     weightValid,
    output logic [2*dataWidth-1:0]   biasValue,
    output logic                     biasValid,
    output logic [2*dataWidth-1:0]   config_layer_num,
    output logic [2*dataWidth-1:0]   config_neuron_num,
    output logic                     cfg_done,
    output logic                     cfg_err,
    output logic [2:0]               dbg_state_o
);
    localparam int W = 2 * dataWidth;

    // One extra counter bit so an illegal count N can be drained as N+1
    // words (weights plus bias) without wrapping.
    localparam logic [cntWidth:0] MAX_CNT = (cntWidth+1)'(maxWeight);
    localparam logic [cntWidth:0] CNT_ONE = (cntWidth+1)'(1);

    typedef enum logic [2:0] {
        S_HDR   = 3'd0,
        S_WGT   = 3'd1,
        S_BIAS  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [cntWidth:0] cnt_q, cnt_d;
    logic [W-1:0]      wval_q, wval_d;
    logic              wstb_q, wstb_d;
    logic [W-1:0]      bval_q, bval_d;
    logic              bstb_q, bstb_d;
    logic [W-1:0]      layer_q, layer_d;
    logic [W-1:0]      neuron_q, neuron_d;
    logic              err_q, err_d;

    logic              xfer;
    logic [cntWidth:0] hdr_cnt;

    assign s_if.in_ready = (state_q != S_DONE);
    assign xfer          = s_if.in_valid && s_if.in_ready;
    assign hdr_cnt       = {1'b0, s_if.in_data[cntWidth-1:0]};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wval_d   = wval_q;
        wstb_d   = 1'b0;
        bval_d   = bval_q;
        bstb_d   = 1'b0;
        layer_d  = layer_q;
        neuron_d = neuron_q;
        err_d    = err_q;

        case (state_q)
            S_HDR: begin
                if (xfer) begin
                    layer_d  = W'(s_if.in_data[W-1 -: 8]);
                    neuron_d = W'(s_if.in_data[W-9 -: 8]);
                    if (hdr_cnt == '0) begin
                        cnt_d   = '0;
                        state_d = S_BIAS;
                    end else if (hdr_cnt > MAX_CNT) begin
                        err_d   = 1'b1;
                        cnt_d   = hdr_cnt + CNT_ONE;
                        state_d = S_DRAIN;
                    end else begin
                        cnt_d   = hdr_cnt;
                        state_d = S_WGT;
                    end
                end
            end
            S_WGT: begin
                if (xfer) begin
                    wval_d = s_if.in_data;
                    wstb_d = 1'b1;
                    cnt_d  = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = S_BIAS;
                    end
                end
            end
            S_BIAS: begin
                if (xfer) begin
                    bval_d  = s_if.in_data;
                    bstb_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DRAIN: begin
                // Swallow the rest of an illegal packet so the stream
                // realigns on the next header.
                if (xfer) begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = S_HDR;
                    end
                end
            end
            S_DONE: begin
                state_d = S_HDR;
            end
            default: begin
                state_d = S_HDR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_HDR;
            cnt_q    <= '0;
            wval_q   <= '0;
            wstb_q   <= 1'b0;
            bval_q   <= '0;
            bstb_q   <= 1'b0;
            layer_q  <= '0;
            neuron_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wval_q   <= wval_d;
            wstb_q   <= wstb_d;
            bval_q   <= bval_d;
            bstb_q   <= bstb_d;
            layer_q  <= layer_d;
            neuron_q <= neuron_d;
            err_q    <= err_d;
        end
    end

    assign weightValue       = wval_q;
    assign weightValid       = wstb_q;
    assign biasValue         = bval_q;
    assign biasValid         = bstb_q;
    assign config_layer_num  = layer_q;
    assign config_neuron_num = neuron_q;
    // DONE is entered on the edge that registers the bias strobe, so the
    // pulse coincides with biasValid and with in_ready low.
    assign cfg_done          = (state_q == S_DONE);
    assign cfg_err           = err_q;
    assign dbg_state_o       = state_q;
endmodule

// File: tb/tb_neuron_config_loader.sv
module tb_neuron_config_loader;
    localparam int W    = 32;
    localparam int MAXW = 784;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    neuron_config_loader_if #(.W(W)) bus();

    logic [W-1:0] weightValue, biasValue, config_layer_num, config_neuron_num;
    logic         weightValid, biasValid, cfg_done, cfg_err;
    logic [2:0]   dbg_state;

    neuron_config_loader #(.dataWidth(16), .maxWeight(MAXW), .cntWidth(16)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .s_if             (bus),
        .weightValue      (weightValue),
        .weightValid      (weightValid),
        .biasValue        (biasValue),
        .biasValid        (biasValid),
        .config_layer_num (config_layer_num),
        .config_neuron_num(config_neuron_num),
        .cfg_done         (cfg_done),
        .cfg_err          (cfg_err),
        .dbg_state_o      (dbg_state)
    );

    int checks = 0;
    int errors = 0;

    // Scoreboard: entries are {layer[7:0], neuron[7:0], value[31:0]}
    logic [47:0] exp_w[$], obs_w[$];
    logic [47:0] exp_b[$], obs_b[$];
    int exp_done, obs_done, exp_b2b, obs_b2b;
    logic prev_wv = 1'b0;

    // Monitor: sample on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (weightValid) begin
                obs_w.push_back({config_layer_num[7:0], config_neuron_num[7:0], weightValue});
                if (prev_wv) obs_b2b++;
            end
            if (biasValid)
                obs_b.push_back({config_layer_num[7:0], config_neuron_num[7:0], biasValue});
            if (weightValid || biasValid) begin
                checks++;
                if ((weightValid && biasValid) || config_layer_num[W-1:8] != 0 || config_neuron_num[W-1:8] != 0) begin
                    errors++;
                    $display("FAIL strobe_sanity: wv=%0b bv=%0b layer=%h neuron=%h, required exclusive strobes and zero-extended tags",
                             weightValid, biasValid, config_layer_num, config_neuron_num);
                end
            end
            if (cfg_done) begin
                obs_done++;
                checks++;
                if (!(biasValid && !bus.in_ready)) begin
                    errors++;
                    $display("FAIL done_align: biasValid=%0b in_ready=%0b, required 1/0", biasValid, bus.in_ready);
                end
            end
            prev_wv = weightValid;
        end else begin
            prev_wv = 1'b0;
        end
    end

    task automatic clear_obs();
        exp_w.delete(); obs_w.delete();
        exp_b.delete(); obs_b.delete();
        exp_done = 0; obs_done = 0; exp_b2b = 0; obs_b2b = 0;
    endtask

    // Present one word and hold it until accepted. Entered and left at #1 after a posedge.
    task automatic send_word(input logic [W-1:0] d, input bit gap);
        int k;
        if (gap) begin
            bus.in_valid = 1'b0;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        k = 0;
        @(negedge clk);
        while (!bus.in_ready && k < 50) begin
            k++;
            @(negedge clk);
        end
        if (!bus.in_ready) begin
            checks++; errors++;
            $display("FAIL ready_timeout: in_ready=0 for %0d cycles, required 1", k);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_data  = $urandom;
    endtask

    // Reference model: a legal packet yields its weights in order, then its bias,
    // then one done pulse, all tagged with the header's layer/neuron.
    // mode: 0 back-to-back, 1 valid toggles every cycle, 2 random gaps.
    task automatic send_packet(input logic [7:0] l, input logic [7:0] nn, input int n,
                               input int mode, input bit fixed);
        logic [W-1:0] w;
        bit gap;
        gap = (mode == 1) || (mode == 2 && 1'($urandom_range(0, 1)));
        send_word({l, nn, 16'(n)}, gap);
        for (int i = 0; i < n; i++) begin
            w = fixed ? 32'h11 + i : $urandom;
            exp_w.push_back({l, nn, w});
            gap = (mode == 1) || (mode == 2 && 1'($urandom_range(0, 1)));
            send_word(w, gap);
        end
        w = fixed ? 32'h55 : $urandom;
        if (n == 0 && fixed) w = 32'h7;
        exp_b.push_back({l, nn, w});
        exp_done++;
        if (mode == 0 && n > 0) exp_b2b += n - 1;
        gap = (mode == 1) || (mode == 2 && 1'($urandom_range(0, 1)));
        send_word(w, gap);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({weightValue, weightValid, biasValue, biasValid, config_layer_num, config_neuron_num,
             cfg_done, cfg_err, bus.in_ready} !== {{W{1'b0}}, 1'b0, {W{1'b0}}, 1'b0, {W{1'b0}}, {W{1'b0}}, 3'b001}) begin
            errors++;
            $display("FAIL reset_state: wv=%h/%0b bv=%h/%0b L=%h N=%h done=%0b err=%0b rdy=%0b, required all 0 and rdy=1",
                     weightValue, weightValid, biasValue, biasValid, config_layer_num, config_neuron_num,
                     cfg_done, cfg_err, bus.in_ready);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        clear_obs();
        send_packet(8'd1, 8'd3, 4, 0, 1'b1);
        repeat (3) @(posedge clk); #1;
        checks++;
        if (obs_w.size() != 4) begin
            errors++; $display("FAIL basic_wcount: got %0d, required 4", obs_w.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (obs_w[i] !== {8'd1, 8'd3, 32'h11 + i}) begin
                    errors++; $display("FAIL basic_weight%0d: got %h, required %h", i, obs_w[i], {8'd1, 8'd3, 32'h11 + i});
                end
            end
        end
        checks++;
        if (obs_b.size() != 1 || obs_b[0] !== {8'd1, 8'd3, 32'h55}) begin
            errors++; $display("FAIL basic_bias: count %0d, required one bias 0x55 for L1/N3", obs_b.size());
        end
        checks++;
        if (obs_done != 1 || obs_b2b != 3) begin
            errors++; $display("FAIL basic_done_b2b: done=%0d b2b=%0d, required 1 and 3", obs_done, obs_b2b);
        end
        checks++;
        if (config_layer_num !== 32'd1 || config_neuron_num !== 32'd3) begin
            errors++; $display("FAIL basic_hold: L=%h N=%h after done, required 1/3", config_layer_num, config_neuron_num);
        end
    endtask

    task automatic test_gaps();
        clear_obs();
        send_packet(8'd1, 8'd3, 4, 1, 1'b1);
        repeat (3) @(posedge clk); #1;
        checks++;
        if (obs_w != exp_w || obs_b != exp_b) begin
            errors++; $display("FAIL gaps_values: w %0d b %0d entries, required %0d/%0d matching", obs_w.size(), obs_b.size(), exp_w.size(), exp_b.size());
        end
        checks++;
        if (obs_b2b != 0 || obs_done != 1) begin
            errors++; $display("FAIL gaps_spacing: b2b=%0d done=%0d, required 0 and 1", obs_b2b, obs_done);
        end
    endtask

    task automatic test_zero_weights();
        clear_obs();
        send_packet(8'd5, 8'd9, 0, 0, 1'b1);
        repeat (3) @(posedge clk); #1;
        checks++;
        if (obs_w.size() != 0 || obs_b.size() != 1 || obs_done != 1) begin
            errors++; $display("FAIL zero_counts: w=%0d b=%0d done=%0d, required 0/1/1", obs_w.size(), obs_b.size(), obs_done);
        end else begin
            checks++;
            if (obs_b[0] !== {8'd5, 8'd9, 32'h7}) begin
                errors++; $display("FAIL zero_bias: got %h, required %h", obs_b[0], {8'd5, 8'd9, 32'h7});
            end
        end
    endtask

    task automatic test_overflow();
        clear_obs();
        send_word({8'd4, 8'd4, 16'(MAXW + 1)}, 1'b0);
        for (int i = 0; i < MAXW + 2; i++)
            send_word($urandom, 1'($urandom_range(0, 1)));
        repeat (3) @(posedge clk); #1;
        checks++;
        if (obs_w.size() != 0 || obs_b.size() != 0 || obs_done != 0 || cfg_err !== 1'b1) begin
            errors++; $display("FAIL overflow_drain: w=%0d b=%0d done=%0d err=%0b, required 0/0/0/1",
                               obs_w.size(), obs_b.size(), obs_done, cfg_err);
        end
        clear_obs();
        send_packet(8'd6, 8'd2, 3, 2, 1'b0);
        repeat (3) @(posedge clk); #1;
        checks++;
        if (obs_w != exp_w || obs_b != exp_b || obs_done != 1) begin
            errors++; $display("FAIL overflow_recover: w=%0d b=%0d done=%0d, required 3/1/1 matching", obs_w.size(), obs_b.size(), obs_done);
        end
        checks++;
        if (cfg_err !== 1'b1) begin
            errors++; $display("FAIL overflow_sticky: cfg_err=%0b, required 1", cfg_err);
        end
    endtask

    task automatic test_reset_mid();
        clear_obs();
        send_word({8'd1, 8'd3, 16'd4}, 1'b0);
        send_word(32'hA1, 1'b0);
        send_word(32'hA2, 1'b0);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({weightValue, weightValid, biasValue, biasValid, config_layer_num, config_neuron_num,
             cfg_done, cfg_err, bus.in_ready} !== {{W{1'b0}}, 1'b0, {W{1'b0}}, 1'b0, {W{1'b0}}, {W{1'b0}}, 3'b001}) begin
            errors++;
            $display("FAIL midreset_state: wv=%h/%0b bv=%h/%0b L=%h N=%h done=%0b err=%0b rdy=%0b, required all 0 and rdy=1",
                     weightValue, weightValid, biasValue, biasValid, config_layer_num, config_neuron_num,
                     cfg_done, cfg_err, bus.in_ready);
        end
        checks++;
        if (obs_done != 0) begin
            errors++; $display("FAIL midreset_nodone: done=%0d, required 0", obs_done);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_obs();
        send_packet(8'd2, 8'd0, 1, 0, 1'b0);
        repeat (3) @(posedge clk); #1;
        checks++;
        if (obs_w != exp_w || obs_b != exp_b || obs_done != 1) begin
            errors++; $display("FAIL midreset_reload: w=%0d b=%0d done=%0d, required 1/1/1 matching", obs_w.size(), obs_b.size(), obs_done);
        end
    endtask

    task automatic test_back_to_back();
        clear_obs();
        send_packet(8'd1, 8'd0, MAXW, 0, 1'b0);
        send_packet(8'd1, 8'd1, MAXW, 0, 1'b0);
        repeat (3) @(posedge clk); #1;
        checks++;
        if (obs_w.size() != 2 * MAXW) begin
            errors++; $display("FAIL b2b_wcount: got %0d, required %0d", obs_w.size(), 2 * MAXW);
        end else begin
            for (int i = 0; i < 2 * MAXW; i++) begin
                checks++;
                if (obs_w[i] !== exp_w[i]) begin
                    errors++; $display("FAIL b2b_weight%0d: got %h, required %h", i, obs_w[i], exp_w[i]);
                end
            end
        end
        checks++;
        if (obs_b != exp_b || obs_done != 2 || obs_b2b != exp_b2b) begin
            errors++; $display("FAIL b2b_tail: b=%0d done=%0d b2b=%0d, required 2/2/%0d", obs_b.size(), obs_done, obs_b2b, exp_b2b);
        end
    endtask

    task automatic test_random();
        for (int p = 0; p < 6; p++) begin
            clear_obs();
            send_packet(8'($urandom), 8'($urandom), $urandom_range(0, 12), $urandom_range(0, 2), 1'b0);
            repeat (3) @(posedge clk); #1;
            checks++;
            if (obs_w != exp_w || obs_b != exp_b || obs_done != exp_done) begin
                errors++; $display("FAIL random_pkt%0d: w=%0d b=%0d done=%0d, required %0d/%0d/%0d matching",
                                   p, obs_w.size(), obs_b.size(), obs_done, exp_w.size(), exp_b.size(), exp_done);
            end
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        test_reset();
        test_basic();
        test_gaps();
        test_zero_weights();
        test_random();
        test_overflow();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
